// File: rtl/id_alu_sequencer_if.sv
// Handshake and datapath-control bundle between the run requester / ID FSM and the
// id_alu_sequencer.
//   start, abort   : run request and cancel from the top-level controller
//   id_digit       : current student-ID digit presented by the ID FSM
//   fsm_step/reset : advance / clear the ID FSM
//   load_a/load_b  : operand register load enables
//   alu_op         : ALU opcode (0 = NOP)
//   result_we      : result register write enable
//   busy/done/err  : run status; done is a one-cycle pulse, err is sticky per run
//   digit_count    : digits executed in the current or last run
// The slave modport is the sequencer; the master modport is its environment.
interface id_alu_sequencer_if;
  logic       start;
  logic       abort;
  logic [3:0] id_digit;
  logic       fsm_step;
  logic       fsm_reset;
  logic       load_a;
  logic       load_b;
  logic [3:0] alu_op;
  logic       result_we;
  logic       busy;
  logic       done;
  logic       err;
  logic [3:0] digit_count;

  modport master (
    output start, abort, id_digit,
    input  fsm_step, fsm_reset, load_a, load_b, alu_op, result_we, busy, done, err,
           digit_count
  );

  modport slave (
    input  start, abort, id_digit,
    output fsm_step, fsm_reset, load_a, load_b, alu_op, result_we, busy, done, err,
           digit_count
  );
endinterface

// File: rtl/id_alu_sequencer.sv
// Run controller for the ID-driven ALU datapath. On start it clears the ID FSM, loads
// operands A and B, then alternates FETCH (step the FSM) and EXEC (issue the digit as an
// ALU opcode and write the result back) once per digit, ending with a one-cycle done.
// Ports:
//   clk    : rising-edge clock
//   reset  : synchronous active-high reset, returns to IDLE and clears count/err
//   seq_io : id_alu_sequencer_if.slave bundle (start/abort/id_digit in, controls out)
// Parameters:
//   NUM_DIGITS : digits sequenced per run (1..15)
//   MAX_OPCODE : highest legal opcode; larger digits execute as NOP and set err
module id_alu_sequencer #(
  parameter int unsigned NUM_DIGITS = 8,
  parameter int unsigned MAX_OPCODE = 9
) (
  input logic               clk,
  input logic               reset,
  id_alu_sequencer_if.slave seq_io
);

  typedef enum logic [2:0] {
    StIdle,
    StClr,
    StLdA,
    StLdB,
    StFetch,
    StExec,
    StDone
  } state_e;

  localparam logic [3:0] LastIdx = 4'(NUM_DIGITS - 1);
  localparam logic [3:0] MaxOp   = 4'(MAX_OPCODE);

  state_e     state_q, state_d;
  logic [3:0] count_q, count_d;
  logic       err_q, err_d;
  logic       digit_legal;
  logic       busy;

  assign digit_legal = (seq_io.id_digit <= MaxOp);
  assign busy = (state_q == StClr) || (state_q == StLdA) || (state_q == StLdB) ||
                (state_q == StFetch) || (state_q == StExec);

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    err_d   = err_q;
    unique case (state_q)
      StIdle:  if (seq_io.start) state_d = StClr;
      StClr: begin
        count_d = 4'd0;
        err_d   = 1'b0;
        state_d = StLdA;
      end
      StLdA:   state_d = StLdB;
      StLdB:   state_d = StFetch;
      StFetch: state_d = StExec;
      StExec: begin
        // The EXEC bookkeeping completes even if this cycle is aborted.
        count_d = count_q + 4'd1;
        if (!digit_legal) err_d = 1'b1;
        state_d = (count_q == LastIdx) ? StDone : StFetch;
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
    if (busy && seq_io.abort) state_d = StIdle;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      count_q <= 4'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    seq_io.fsm_step    = 1'b0;
    seq_io.fsm_reset   = 1'b0;
    seq_io.load_a      = 1'b0;
    seq_io.load_b      = 1'b0;
    seq_io.alu_op      = 4'd0;
    seq_io.result_we   = 1'b0;
    seq_io.busy        = busy;
    seq_io.done        = 1'b0;
    // err is visible already in the EXEC cycle that sees the illegal digit.
    seq_io.err         = err_q;
    seq_io.digit_count = count_q;
    unique case (state_q)
      StClr:   seq_io.fsm_reset = 1'b1;
      StLdA:   seq_io.load_a    = 1'b1;
      StLdB:   seq_io.load_b    = 1'b1;
      StFetch: seq_io.fsm_step  = 1'b1;
      StExec: begin
        if (digit_legal) begin
          seq_io.alu_op    = seq_io.id_digit;
          seq_io.result_we = 1'b1;
        end else begin
          seq_io.err = 1'b1;
        end
      end
      StDone:  seq_io.done = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_id_alu_sequencer.sv
// Scoreboard bench for id_alu_sequencer: stimulus pushes expected strobe events (with
// cycle stamps) into a queue, a negedge monitor pops and compares them. A second
// instance with NUM_DIGITS=1 is checked cycle by cycle.
module tb_id_alu_sequencer;
  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  id_alu_sequencer_if bus0 ();
  id_alu_sequencer_if bus1 ();

  id_alu_sequencer #(.NUM_DIGITS(8), .MAX_OPCODE(9)) u_dut0 (
    .clk    (clk),
    .reset  (reset),
    .seq_io (bus0.slave)
  );

  id_alu_sequencer #(.NUM_DIGITS(1), .MAX_OPCODE(9)) u_dut1 (
    .clk    (clk),
    .reset  (reset),
    .seq_io (bus1.slave)
  );

  // Model of the student-ID FSM: shows the next digit after each step.
  logic [3:0] dig [8];
  int         pos = 0;
  logic [3:0] cur = 4'd0;
  always @(posedge clk) begin
    if (bus0.fsm_reset) begin
      pos <= 0;
      cur <= 4'd0;
    end else if (bus0.fsm_step) begin
      cur <= dig[pos % 8];
      pos <= pos + 1;
    end
  end
  assign bus0.id_digit = cur;

  int checks = 0;
  int passed = 0;

  task automatic chk(string name, int act, int req);
    checks++;
    if (act == req) passed++;
    else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
  endtask

  // Event kinds: 0 load_a, 1 load_b, 2 result_we (data=alu_op), 3 done (data=16*err+count)
  typedef struct {
    int kind;
    int c;
    int data;
  } ev_t;
  ev_t exp_q[$];

  task automatic push(int kind, int c, int data, int last);
    ev_t e;
    if (c <= last) begin
      e.kind = kind;
      e.c    = c;
      e.data = data;
      exp_q.push_back(e);
    end
  endtask

  // Expected events of an 8-digit run whose start is sampled at the end of cycle t0,
  // truncated after cycle `last` (abort/reset).
  task automatic push_run(int t0, int last);
    int e = 0;
    push(0, t0 + 2, 0, last);
    push(1, t0 + 3, 0, last);
    for (int i = 0; i < 8; i++) begin
      if (dig[i] <= 4'd9) push(2, t0 + 5 + 2 * i, int'(dig[i]), last);
      else e = 1;
    end
    push(3, t0 + 20, 16 * e + 8, last);
  endtask

  task automatic observe(int kind, int data);
    ev_t e;
    if (exp_q.size() == 0) begin
      chk($sformatf("unexpected_event_kind%0d", kind), 1, 0);
    end else begin
      e = exp_q.pop_front();
      chk("ev_kind", kind, e.kind);
      chk("ev_cycle", cyc, e.c);
      chk("ev_data", data, e.data);
    end
  endtask

  always @(negedge clk) begin
    int n;
    n = int'(bus0.load_a) + int'(bus0.load_b) + int'(bus0.fsm_step) + int'(bus0.result_we);
    if (n > 1) chk("strobe_onehot", n, 1);
    if (bus0.load_a)    observe(0, 0);
    if (bus0.load_b)    observe(1, 0);
    if (bus0.result_we) observe(2, int'(bus0.alu_op));
    if (bus0.done)      observe(3, 16 * int'(bus0.err) + int'(bus0.digit_count));
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_until(int c);
    while (cyc < c) tick();
  endtask

  task automatic start_run(output int t0);
    bus0.start = 1'b1;
    t0 = cyc;
    tick();
    bus0.start = 1'b0;
  endtask

  task automatic set_dig(input logic [31:0] d);
    for (int i = 0; i < 8; i++) dig[i] = d[31 - 4 * i -: 4];
  endtask

  task automatic check_cleared(string tag);
    chk({tag, "_busy"}, int'(bus0.busy), 0);
    chk({tag, "_count"}, int'(bus0.digit_count), 0);
    chk({tag, "_alu_op"}, int'(bus0.alu_op), 0);
    chk({tag, "_err"}, int'(bus0.err), 0);
    chk({tag, "_strobes"}, int'({bus0.load_a, bus0.load_b, bus0.fsm_step, bus0.result_we,
                                 bus0.fsm_reset, bus0.done}), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  logic [6:0] vec1 [7];

  initial begin
    int t0;
    reset      = 1'b1;
    bus0.start = 1'b0;
    bus0.abort = 1'b0;
    bus1.start = 1'b0;
    bus1.abort = 1'b0;
    bus1.id_digit = 4'd7;
    set_dig(32'h1234_5678);
    tick();
    tick();
    reset = 1'b0;
    check_cleared("reset0");
    chk("reset1_busy_done", int'({bus1.busy, bus1.done, bus1.err}), 0);

    // 1: plain run, digits 1..8
    start_run(t0);
    push_run(t0, t0 + 100);
    wait_until(t0 + 24);
    chk("t1_count_hold", int'(bus0.digit_count), 8);
    chk("t1_err", int'(bus0.err), 0);

    // 2: illegal digit 4'hC at position 3 (EXEC at +11)
    set_dig(32'h123C_5678);
    start_run(t0);
    push_run(t0, t0 + 100);
    wait_until(t0 + 10);
    chk("t2_err_before", int'(bus0.err), 0);
    wait_until(t0 + 11);
    chk("t2_illegal_alu_op", int'(bus0.alu_op), 0);
    chk("t2_illegal_we", int'(bus0.result_we), 0);
    chk("t2_err_exec", int'(bus0.err), 1);
    tick();
    chk("t2_err_after", int'(bus0.err), 1);
    wait_until(t0 + 24);

    // 3: start held through a run and the IDLE cycle after done -> exactly two runs
    set_dig(32'h9090_1111);
    bus0.start = 1'b1;
    t0 = cyc;
    push_run(t0, t0 + 100);
    push_run(t0 + 21, t0 + 200);
    wait_until(t0 + 20);
    chk("t3_done", int'(bus0.done), 1);
    wait_until(t0 + 21);
    chk("t3_idle_busy", int'(bus0.busy), 0);
    wait_until(t0 + 22);
    bus0.start = 1'b0;
    chk("t3_second_run_busy", int'(bus0.busy), 1);
    wait_until(t0 + 21 + 26);

    // 4: abort in the third EXEC (+9); digit 1 illegal so err is set beforehand
    set_dig(32'h2F45_6789);
    start_run(t0);
    push_run(t0, t0 + 9);
    wait_until(t0 + 9);
    bus0.abort = 1'b1;
    tick();
    bus0.abort = 1'b0;
    chk("t4_busy", int'(bus0.busy), 0);
    chk("t4_done", int'(bus0.done), 0);
    chk("t4_count", int'(bus0.digit_count), 3);
    chk("t4_err_hold", int'(bus0.err), 1);
    wait_until(t0 + 26);
    set_dig(32'h1234_5678);
    start_run(t0);
    push_run(t0, t0 + 100);
    wait_until(t0 + 2);
    chk("t4b_count_clr", int'(bus0.digit_count), 0);
    chk("t4b_err_clr", int'(bus0.err), 0);
    wait_until(t0 + 24);

    // 5: reset in FETCH of digit 5 (+14), then abort+reset together in EXEC (+7)
    set_dig(32'h12A4_5678);
    start_run(t0);
    push_run(t0, t0 + 14);
    wait_until(t0 + 14);
    chk("t5_in_fetch", int'(bus0.fsm_step), 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_cleared("t5_reset");
    tick();
    set_dig(32'h1234_5678);
    start_run(t0);
    push_run(t0, t0 + 7);
    wait_until(t0 + 7);
    bus0.abort = 1'b1;
    reset      = 1'b1;
    tick();
    bus0.abort = 1'b0;
    reset      = 1'b0;
    check_cleared("t5_abort_reset");
    tick();

    // 6: NUM_DIGITS=1 instance, {fsm_reset,load_a,load_b,fsm_step,result_we,done,busy}
    vec1[0] = 7'b1000001;
    vec1[1] = 7'b0100001;
    vec1[2] = 7'b0010001;
    vec1[3] = 7'b0001001;
    vec1[4] = 7'b0000101;
    vec1[5] = 7'b0000010;
    vec1[6] = 7'b0000000;
    bus1.start = 1'b1;
    t0 = cyc;
    tick();
    bus1.start = 1'b0;
    for (int d = 1; d <= 7; d++) begin
      chk($sformatf("t6_vec_p%0d", d),
          int'({bus1.fsm_reset, bus1.load_a, bus1.load_b, bus1.fsm_step, bus1.result_we,
                bus1.done, bus1.busy}), int'(vec1[d - 1]));
      if (d == 5) chk("t6_alu_op", int'(bus1.alu_op), 7);
      if (d == 6) chk("t6_count", int'(bus1.digit_count), 1);
      tick();
    end

    tick();
    chk("scoreboard_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
